recovery_ctrl: RTL and testbench
================================

// Module: recovery_ctrl
//
// PURPOSE
//   Sequences branch-mispredict recovery once the retire stage flags a mispredicted head branch.
//   - Squashes the pipeline and holds dispatch.
//   - Restores the speculative map table from the precise (arch) map, COPY_W entries per cycle.
//   - Pulses the freelist reseed, then issues the fetch redirect with a valid/ready handshake.
//   Sits between retire (mispredict source) and map_table / freelist / fetch (recovery consumers).
//
// PARAMETERS
//   N          `N                    superscalar width (carried for consistency; unused in datapath)
//   ARCH_COUNT 32                    architectural registers
//   PHYS_REGS  `PHYS_REG_SZ_R10K     physical registers; PRW = $clog2(PHYS_REGS), min 1
//   COPY_W     8                     map entries restored per COPY cycle; ARCH_COUNT % COPY_W == 0 (elab error otherwise)
//   DRAIN_CYC  2                     squash cycles for in-flight FU/CDB traffic to drain; >= 1
//   AW         $clog2(ARCH_COUNT)    localparam
//
// PORTS
//   clock           in   1                   system clock, rising edge
//   reset           in   1                   asynchronous, active-low reset (0 = reset)
//   mispredict_in   in   1                   retire: oldest head branch mispredicted (rob_mispredict)
//   mispred_pc      in   `XLEN               correct target PC, valid with mispredict_in
//   archi_maptable  in   ARCH_COUNT*PRW      precise map image
//   flush           out  1                   squash ROB/RS/FUs
//   stall_dispatch  out  1                   block dispatch/rename
//   copy_en         out  1                   map_table: write COPY_W entries this cycle
//   copy_base       out  AW                  first arch reg index of the copy window
//   copy_data       out  COPY_W*PRW          archi_maptable[copy_base +: COPY_W]
//   fl_reseed       out  1                   freelist: rebuild from archi_maptable (1-cycle pulse)
//   redirect_valid  out  1                   fetch redirect request
//   redirect_pc     out  `XLEN               redirect target
//   redirect_ready  in   1                   fetch accepts redirect
//   busy            out  1                   state != IDLE
//   recov_count     out  16                  completed recoveries; saturates at 16'hFFFF
//
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE; all counters, latched PC and outputs = 0. Reset mid-recovery aborts immediately.
//   - Moore outputs, all decoded from registered state.
//   - FSM:
//     - IDLE: mispredict_in==1 -> latch mispred_pc; drain_cnt=0; next DRAIN. Otherwise stay.
//     - DRAIN: flush=1. drain_cnt++; leave when drain_cnt==DRAIN_CYC-1 -> COPY with copy_idx=0.
//     - COPY: copy_en=1; copy_base=copy_idx*COPY_W; copy_data sliced combinationally from the live archi_maptable.
//       - The map is stable because retire is quiesced.
//       - copy_idx++; after ARCH_COUNT/COPY_W cycles -> RESEED.
//     - RESEED: fl_reseed=1 for exactly 1 cycle -> REDIRECT.
//     - REDIRECT: redirect_valid=1; redirect_pc=latched PC, stable until accepted.
//       - redirect_ready==1 -> IDLE; recov_count++ (saturating).
//   - stall_dispatch = busy = (state != IDLE). flush is 0 outside DRAIN. copy_en is 0 outside COPY.
//   - copy_base/copy_data are 0 when copy_en==0.
//   - mispredict_in while busy: ignored; no re-latch, no restart. The latched PC is immutable until IDLE.
//   - redirect_ready outside REDIRECT: ignored.
//   - IDLE has no input shortcut: mispredict_in in the same cycle REDIRECT completes is ignored.
//     A new recovery starts only from IDLE on a later cycle.
//   - Latency, mispredict sampled at edge 0, defaults: DRAIN cycles 1-2, COPY cycles 1-4 of window (3-6),
//     RESEED 7, REDIRECT from 8. Total = DRAIN_CYC + ARCH_COUNT/COPY_W + 1 cycles before redirect_valid.
//   - Widths: copy_idx is $clog2(ARCH_COUNT/COPY_W+1) bits. copy_base is computed in AW bits, with no overflow since ARCH_COUNT%COPY_W==0.
//
// TESTING
//   1. Reset, then idle 10 cycles -> every output 0, busy=0, recov_count=0.
//   2. mispredict_in=1, mispred_pc=32'h0000_1040 at cycle 0, redirect_ready tied 1:
//      -> flush at cycles 1-2; copy_en at 3-6 with copy_base 0,8,16,24; fl_reseed at 7;
//         redirect_valid at 8 with pc 32'h1040; busy=0 at 9; recov_count=1.
//   3. archi_maptable[i]=i+32 -> copy_data word j at copy_base=16 equals 48+j, for all j<8.
//   4. redirect_ready held 0 for 5 cycles in REDIRECT -> redirect_valid/pc stable; done in cycle of ready=1.
//   5. Second mispredict_in (pc 32'h2000) during COPY -> ignored; redirect_pc stays 32'h1040; recov_count=1.
//   6. Reset asserted during COPY (copy_base=8) -> all outputs 0 asynchronously; after release, IDLE, recov_count=0.

Source files
------------

// File: rtl/recovery_ctrl.sv
// Branch-mispredict recovery sequencer: squash/drain, restore the speculative map
// from the arch map in COPY_W-wide windows, reseed the freelist, then redirect fetch.
module recovery_ctrl #(
   parameter int N          = 2,
   parameter int ARCH_COUNT = 32,
   parameter int PHYS_REGS  = 64,
   parameter int COPY_W     = 8,
   parameter int DRAIN_CYC  = 2,
   parameter int XLEN       = 32,
   localparam int PRW       = ($clog2(PHYS_REGS) < 1) ? 1 : $clog2(PHYS_REGS),
   localparam int AW        = ($clog2(ARCH_COUNT) < 1) ? 1 : $clog2(ARCH_COUNT)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mispredict_in,
   input  logic [XLEN-1:0]           mispred_pc,
   input  logic [ARCH_COUNT*PRW-1:0] archi_maptable,
   output logic                      flush,
   output logic                      stall_dispatch,
   output logic                      copy_en,
   output logic [AW-1:0]             copy_base,
   output logic [COPY_W*PRW-1:0]     copy_data,
   output logic                      fl_reseed,
   output logic                      redirect_valid,
   output logic [XLEN-1:0]           redirect_pc,
   input  logic                      redirect_ready,
   output logic                      busy,
   output logic [15:0]               recov_count
);

   localparam int NWIN = ARCH_COUNT / COPY_W;
   localparam int CIW  = ($clog2(NWIN + 1) < 1) ? 1 : $clog2(NWIN + 1);
   localparam int DW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CIW-1:0] LAST_WIN   = CIW'(NWIN - 1);
   localparam logic [DW-1:0]  LAST_DRAIN = DW'(DRAIN_CYC - 1);

   if (N < 1 || DRAIN_CYC < 1 || COPY_W < 1 || (ARCH_COUNT % COPY_W) != 0) begin : g_param_check
      $error("recovery_ctrl: illegal parameters (need N>=1, DRAIN_CYC>=1, ARCH_COUNT %% COPY_W == 0)");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      COPY     = 3'd2,
      RESEED   = 3'd3,
      REDIRECT = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    drain_cnt;
   logic [CIW-1:0]   copy_idx;
   logic [XLEN-1:0]  pc_q;
   logic [AW-1:0]    win_base;

   assign win_base = AW'(int'(copy_idx) * COPY_W);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (mispredict_in)           state_nxt = DRAIN;
         DRAIN:    if (drain_cnt == LAST_DRAIN) state_nxt = COPY;
         COPY:     if (copy_idx == LAST_WIN)    state_nxt = RESEED;
         RESEED:                                state_nxt = REDIRECT;
         REDIRECT: if (redirect_ready)          state_nxt = IDLE;
         default:                               state_nxt = IDLE;
      endcase
   end

   // Counters and the latched PC; the PC only moves on an IDLE->DRAIN launch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         drain_cnt   <= '0;
         copy_idx    <= '0;
         pc_q        <= '0;
         recov_count <= '0;
      end else begin
         case (state)
            IDLE: if (mispredict_in) begin
               pc_q      <= mispred_pc;
               drain_cnt <= '0;
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == LAST_DRAIN) copy_idx <= '0;
            end
            COPY: copy_idx <= copy_idx + 1'b1;
            REDIRECT: if (redirect_ready && recov_count != 16'hFFFF)
               recov_count <= recov_count + 16'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      flush          = 1'b0;
      copy_en        = 1'b0;
      copy_base      = '0;
      copy_data      = '0;
      fl_reseed      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = (state != IDLE);
      stall_dispatch = (state != IDLE);
      case (state)
         DRAIN:  flush = 1'b1;
         COPY: begin
            copy_en   = 1'b1;
            copy_base = win_base;
            copy_data = archi_maptable[int'(win_base) * PRW +: COPY_W * PRW];
         end
         RESEED: fl_reseed = 1'b1;
         REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = pc_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed bench for recovery_ctrl: a timeline model (offset since launch) checked
// every cycle, plus literal expectations for the documented latencies.
module tb_recovery_ctrl;

   localparam int ARCH_COUNT = 32;
   localparam int PHYS_REGS  = 64;
   localparam int COPY_W     = 8;
   localparam int DRAIN_CYC  = 2;
   localparam int XLEN       = 32;
   localparam int PRW        = 6;
   localparam int AW         = 5;
   localparam int NWIN       = ARCH_COUNT / COPY_W;

   logic                      clock = 1'b0;
   logic                      reset = 1'b1;
   logic                      mispredict_in = 1'b0;
   logic [XLEN-1:0]           mispred_pc = '0;
   logic [ARCH_COUNT*PRW-1:0] archi_maptable;
   logic                      redirect_ready = 1'b1;
   logic                      flush, stall_dispatch, copy_en, fl_reseed, redirect_valid, busy;
   logic [AW-1:0]             copy_base;
   logic [COPY_W*PRW-1:0]     copy_data;
   logic [XLEN-1:0]           redirect_pc;
   logic [15:0]               recov_count;

   int tot = 0;
   int bad = 0;
   int map [ARCH_COUNT];

   recovery_ctrl #(.N(2), .ARCH_COUNT(ARCH_COUNT), .PHYS_REGS(PHYS_REGS), .COPY_W(COPY_W),
                   .DRAIN_CYC(DRAIN_CYC), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .mispredict_in(mispredict_in), .mispred_pc(mispred_pc),
      .archi_maptable(archi_maptable), .flush(flush), .stall_dispatch(stall_dispatch),
      .copy_en(copy_en), .copy_base(copy_base), .copy_data(copy_data), .fl_reseed(fl_reseed),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
      .busy(busy), .recov_count(recov_count)
   );

   always #5 clock = ~clock;

   initial for (int i = 0; i < ARCH_COUNT; i++) map[i] = i + 32;
   always_comb begin
      archi_maptable = '0;
      for (int i = 0; i < ARCH_COUNT; i++) archi_maptable[i*PRW +: PRW] = PRW'(map[i]);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: k = cycles since the launching edge (1 = first drain cycle).
   bit        m_act = 0;
   int        m_k = 0;
   logic [XLEN-1:0] m_pc = '0;
   int        m_cnt = 0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_act = 0; m_k = 0; m_pc = '0; m_cnt = 0;
      end else if (!m_act) begin
         if (mispredict_in) begin
            m_act = 1; m_k = 1; m_pc = mispred_pc;
         end
      end else if (m_k >= DRAIN_CYC + NWIN + 2) begin
         if (redirect_ready) begin
            m_act = 0; m_k = 0;
            if (m_cnt < 65535) m_cnt++;
         end
      end else begin
         m_k++;
      end
   end

   always @(negedge clock) begin
      logic e_flush, e_copy, e_reseed, e_red;
      int   e_base;
      logic [COPY_W*PRW-1:0] e_data;
      e_flush  = m_act && m_k <= DRAIN_CYC;
      e_copy   = m_act && m_k > DRAIN_CYC && m_k <= DRAIN_CYC + NWIN;
      e_reseed = m_act && m_k == DRAIN_CYC + NWIN + 1;
      e_red    = m_act && m_k == DRAIN_CYC + NWIN + 2;
      e_base   = e_copy ? (m_k - DRAIN_CYC - 1) * COPY_W : 0;
      e_data   = '0;
      if (e_copy)
         for (int j = 0; j < COPY_W; j++) e_data[j*PRW +: PRW] = PRW'(map[e_base + j]);
      chk("m_flush", 64'(flush), 64'(e_flush));
      chk("m_copy_en", 64'(copy_en), 64'(e_copy));
      chk("m_copy_base", 64'(copy_base), 64'(e_base));
      chk("m_copy_data", 64'(copy_data), 64'(e_data));
      chk("m_reseed", 64'(fl_reseed), 64'(e_reseed));
      chk("m_redir_valid", 64'(redirect_valid), 64'(e_red));
      chk("m_redir_pc", 64'(redirect_pc), e_red ? 64'(m_pc) : 64'd0);
      chk("m_busy", 64'(busy), 64'(m_act));
      chk("m_stall", 64'(stall_dispatch), 64'(m_act));
      chk("m_count", 64'(recov_count), 64'(m_cnt));
   end

   // Advance one clock; land mid-cycle on the falling edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic launch(input logic [XLEN-1:0] pc);
      mispredict_in = 1'b1;
      mispred_pc    = pc;
      step();
      mispredict_in = 1'b0;
      mispred_pc    = '0;
   endtask

   initial begin
      #1 reset = 1'b0;
      step(2);
      reset = 1'b1;

      // Idle after reset.
      step(10);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_count", 64'(recov_count), 64'd0);
      chk("idle_valid", 64'(redirect_valid), 64'd0);

      // Basic recovery, ready tied high; now in cycle 1.
      launch(32'h0000_1040);
      chk("c1_flush", 64'(flush), 64'd1);
      step();
      chk("c2_flush", 64'(flush), 64'd1);
      step();
      chk("c3_copy_en", 64'(copy_en), 64'd1);
      chk("c3_base", 64'(copy_base), 64'd0);
      step();
      chk("c4_base", 64'(copy_base), 64'd8);
      step();
      chk("c5_base", 64'(copy_base), 64'd16);
      for (int j = 0; j < COPY_W; j++)
         chk($sformatf("c5_word%0d", j), 64'(copy_data[j*PRW +: PRW]), 64'(48 + j));
      step();
      chk("c6_base", 64'(copy_base), 64'd24);
      step();
      chk("c7_reseed", 64'(fl_reseed), 64'd1);
      chk("c7_copy_en", 64'(copy_en), 64'd0);
      step();
      chk("c8_valid", 64'(redirect_valid), 64'd1);
      chk("c8_pc", 64'(redirect_pc), 64'h1040);
      step();
      chk("c9_busy", 64'(busy), 64'd0);
      chk("c9_count", 64'(recov_count), 64'd1);

      // Backpressure on the redirect.
      step(2);
      redirect_ready = 1'b0;
      launch(32'h0000_3000);
      step(7);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(redirect_valid), 64'd1);
         chk("bp_pc", 64'(redirect_pc), 64'h3000);
         step();
      end
      redirect_ready = 1'b1;
      chk("bp_accept_valid", 64'(redirect_valid), 64'd1);
      step();
      chk("bp_done_busy", 64'(busy), 64'd0);
      chk("bp_done_count", 64'(recov_count), 64'd2);

      // Mispredict during COPY ignored; mispredict on the completing cycle ignored.
      step(2);
      launch(32'h0000_1040);
      step(3);
      mispredict_in = 1'b1;
      mispred_pc    = 32'h0000_2000;
      step();
      mispredict_in = 1'b0;
      mispred_pc    = '0;
      step(3);
      chk("ig_pc", 64'(redirect_pc), 64'h1040);
      mispredict_in = 1'b1;
      mispred_pc    = 32'h0000_2000;
      step();
      mispredict_in = 1'b0;
      mispred_pc    = '0;
      chk("ig_busy0", 64'(busy), 64'd0);
      chk("ig_count", 64'(recov_count), 64'd3);
      step();
      chk("ig_busy1", 64'(busy), 64'd0);

      // Asynchronous reset mid-COPY.
      step(2);
      launch(32'h0000_4000);
      step(3);
      chk("rs_pre_base", 64'(copy_base), 64'd8);
      #2 reset = 1'b0;
      #1;
      chk("rs_busy", 64'(busy), 64'd0);
      chk("rs_copy_en", 64'(copy_en), 64'd0);
      chk("rs_copy_data", 64'(copy_data), 64'd0);
      chk("rs_flush", 64'(flush), 64'd0);
      chk("rs_count", 64'(recov_count), 64'd0);
      step(2);
      reset = 1'b1;
      step(3);
      chk("rs_after_busy", 64'(busy), 64'd0);
      chk("rs_after_count", 64'(recov_count), 64'd0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
